alu_mul_seq: RTL

Multi-cycle unsigned 16x16 multiplier (low 16 bits of product plus overflow flag) built by sequencing one alu_hier instance through shift-add iterations. Sits in the execute stage beside the main ALU and serves MUL-class instructions. It uses the existing add, shift-left and shift-right-logical ALU ops, so no new arithmetic hardware is added. Start/busy/done handshake to the pipeline stall logic.

---
 rtl/alu_mul_seq_pkg.sv | 17 +
 rtl/alu_mul_seq_if.sv | 14 +
 rtl/alu_mul_seq_alu_hier.sv | 48 ++++
 rtl/alu_mul_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential multiplier: ALU opcodes it issues
// to alu_hier and the encoding of its control FSM.
package alu_mul_seq_pkg;

  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_SRL = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Start/busy/done handshake and operand/result bus between the pipeline
// stall logic (master) and the sequential multiplier (slave).
interface alu_mul_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;

  modport master (output start, a, b, input busy, done, result, ovf);
  modport slave  (input start, a, b, output busy, done, result, ovf);
endinterface

// File: rtl/alu_mul_seq_alu_hier.sv
// 16-bit execute-stage ALU. Shift amount comes from B[3:0]; Ofl is the
// unsigned carry out for ADD when sign=0, signed overflow when sign=1.
module alu_hier (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  input  logic [3:0]  i_op,
  input  logic        i_inva,
  input  logic        i_invb,
  input  logic        i_sign,
  output logic [15:0] o_out,
  output logic        o_ofl
);

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [3:0]  w_sh;
  logic [16:0] w_sum;
  logic [31:0] w_rot;

  assign w_a   = i_inva ? ~i_a : i_a;
  assign w_b   = i_invb ? ~i_b : i_b;
  assign w_sh  = w_b[3:0];
  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {16'd0, i_cin};
  assign w_rot = {w_a, w_a} << w_sh;

  // Operation select and overflow generation.
  always_comb begin
    o_out = w_a;
    o_ofl = 1'b0;
    case (i_op)
      4'b0000: o_out = w_rot[31:16];
      4'b0001: o_out = w_a << w_sh;
      4'b0010: o_out = $signed(w_a) >>> w_sh;
      4'b0011: o_out = w_a >> w_sh;
      4'b0100: begin
        o_out = w_sum[15:0];
        o_ofl = i_sign ? ((w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]))
                       : w_sum[16];
      end
      4'b0101: o_out = w_a | w_b;
      4'b0110: o_out = w_a ^ w_b;
      4'b0111: o_out = w_a & w_b;
      default: o_out = w_a;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned 16x16 multiplier (low half + overflow) that reuses
// one alu_hier for the add, shift-left and shift-right steps of each
// shift-add iteration. Each iteration takes three cycles: ADD, SHL, SHR.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  alu_mul_seq_if.slave  bus
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [15:0] r_mplier;
  logic [4:0]  r_iter;
  logic        r_ovf_s;
  logic [15:0] r_result;
  logic        r_ovf;

  logic [15:0] w_alu_a;
  logic [15:0] w_alu_b;
  logic [3:0]  w_alu_op;
  logic [15:0] w_alu_out;
  logic        w_alu_ofl;

  alu_hier u_alu (
    .i_a    (w_alu_a),
    .i_b    (w_alu_b),
    .i_cin  (1'b0),
    .i_op   (w_alu_op),
    .i_inva (1'b0),
    .i_invb (1'b0),
    .i_sign (1'b0),
    .o_out  (w_alu_out),
    .o_ofl  (w_alu_ofl)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and ALU operand steering per state.
  always_comb begin
    w_next   = r_state;
    w_alu_a  = r_acc;
    w_alu_b  = r_mcand;
    w_alu_op = OP_ADD;
    case (r_state)
      S_IDLE: begin
        if (bus.start)
          w_next = (EARLY_TERM && (bus.b == 16'd0)) ? S_DONE : S_ADD;
      end
      S_ADD: w_next = S_SHL;
      S_SHL: begin
        w_alu_a  = r_mcand;
        w_alu_b  = 16'd1;
        w_alu_op = OP_SLL;
        w_next   = S_SHR;
      end
      S_SHR: begin
        w_alu_a  = r_mplier;
        w_alu_b  = 16'd1;
        w_alu_op = OP_SRL;
        // The multiplier being emptied means no further partial products.
        if ((r_iter == 5'd15) || (EARLY_TERM && (w_alu_out == 16'd0)))
          w_next = S_DONE;
        else
          w_next = S_ADD;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers updated from the ALU result of the current step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= 16'd0;
      r_mcand  <= 16'd0;
      r_mplier <= 16'd0;
      r_iter   <= 5'd0;
      r_ovf_s  <= 1'b0;
      r_result <= 16'd0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand  <= bus.a;
            r_mplier <= bus.b;
            r_acc    <= 16'd0;
            r_ovf_s  <= 1'b0;
            r_iter   <= 5'd0;
          end
        end
        S_ADD: begin
          if (r_mplier[0]) begin
            r_acc   <= w_alu_out;
            r_ovf_s <= r_ovf_s | w_alu_ofl;
          end
        end
        S_SHL: begin
          r_mcand <= w_alu_out;
          // A multiplicand bit leaves the word while a later multiplier
          // bit would still have added it in.
          if (r_mcand[15] && (r_mplier[15:1] != 15'd0))
            r_ovf_s <= 1'b1;
        end
        S_SHR: begin
          r_mplier <= w_alu_out;
          r_iter   <= r_iter + 5'd1;
        end
        S_DONE: begin
          r_result <= r_acc;
          r_ovf    <= r_ovf_s;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
  assign bus.ovf    = r_ovf;

endmodule
